// File: rtl/systolic_mac_pe.sv
// Systolic-array MAC processing element: truncated 8x8 multiply, K_LEN-term
// accumulation, one-cycle operand forwarding and a valid/ready result port.

module trunc_array_mult8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    // Each row adds one shifted partial product. Only the low 8 columns are
    // built, so bits above the product width are never generated.
    logic [7:0][7:0] row;

    assign row[0] = a & {8{b[0]}};

    for (genvar i = 1; i < 8; i++) begin : g_row
        logic [7:0] pp;
        logic [7:0] c;

        assign pp   = (a << i) & {8{b[i]}};
        assign c[0] = 1'b0;

        for (genvar j = 0; j < 8; j++) begin : g_fa
            assign row[i][j] = row[i-1][j] ^ pp[j] ^ c[j];
            if (j < 7) begin : g_carry
                assign c[j+1] = (row[i-1][j] & pp[j]) | (c[j] & (row[i-1][j] ^ pp[j]));
            end
        end
    end

    assign p = row[7];

endmodule

module systolic_mac_pe #(
    parameter int K_LEN = 4,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       a_in,
    input  logic [7:0]       b_in,
    input  logic             valid_in,
    input  logic             clear,
    output logic [7:0]       a_out,
    output logic [7:0]       b_out,
    output logic             valid_out,
    output logic [ACC_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             result_ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(K_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K_LEN - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [7:0]       prod;
    logic [ACC_W-1:0] prod_ext;
    logic             transfer;

    trunc_array_mult8 u_mult (
        .a (a_in),
        .b (b_in),
        .p (prod)
    );

    assign prod_ext = ACC_W'(prod);
    assign transfer = result_valid && result_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_out     <= '0;
            b_out     <= '0;
            valid_out <= 1'b0;
        end else begin
            a_out     <= a_in;
            b_out     <= b_in;
            valid_out <= valid_in;
        end
    end

    // A completion later in this block overrides the handshake drop, so a
    // transfer and a completion on the same edge leave result_valid high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            result_ovf   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (transfer) begin
                result_valid <= 1'b0;
            end

            if (clear) begin
                state <= IDLE;
                cnt   <= '0;
                acc   <= '0;
                busy  <= 1'b0;
            end else if (valid_in) begin
                case (state)
                    IDLE: begin
                        acc   <= prod_ext;
                        cnt   <= ONE_CNT;
                        state <= ACCUM;
                        busy  <= 1'b1;
                    end
                    ACCUM: begin
                        if (cnt == LAST_CNT) begin
                            result       <= acc + prod_ext;
                            result_valid <= 1'b1;
                            if (result_valid && !result_ready) begin
                                result_ovf <= 1'b1;
                            end
                            acc   <= '0;
                            cnt   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            acc <= acc + prod_ext;
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a term-list model.

module tb_systolic_mac_pe;

    localparam int K0 = 4;
    localparam int W0 = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  a_in = '0;
    logic [7:0]  b_in = '0;
    logic        valid_in = 1'b0;
    logic        clear = 1'b0;
    logic        result_ready = 1'b1;

    logic [7:0]  a_out0, b_out0, a_out1, b_out1;
    logic        valid_out0, valid_out1;
    logic [15:0] result0;
    logic [7:0]  result1;
    logic        rv0, rv1, ovf0, ovf1, busy0, busy1;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    systolic_mac_pe #(.K_LEN(K0), .ACC_W(W0)) dut0 (
        .clk(clk), .reset_n(reset_n), .a_in(a_in), .b_in(b_in),
        .valid_in(valid_in), .clear(clear), .a_out(a_out0), .b_out(b_out0),
        .valid_out(valid_out0), .result(result0), .result_valid(rv0),
        .result_ready(result_ready), .result_ovf(ovf0), .busy(busy0)
    );

    systolic_mac_pe #(.K_LEN(2), .ACC_W(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .a_in(a_in), .b_in(b_in),
        .valid_in(valid_in), .clear(clear), .a_out(a_out1), .b_out(b_out1),
        .valid_out(valid_out1), .result(result1), .result_valid(rv1),
        .result_ready(result_ready), .result_ovf(ovf1), .busy(busy1)
    );

    // Reference: the current dot product is a list of truncated products.
    int exp_a, exp_b, exp_v, exp_res, exp_rv, exp_ovf, exp_busy;
    int terms[$];

    always @(posedge clk) begin
        if (!reset_n) begin
            exp_a = 0; exp_b = 0; exp_v = 0;
            exp_res = 0; exp_rv = 0; exp_ovf = 0; exp_busy = 0;
            terms.delete();
        end else begin
            int old_rv;
            old_rv = exp_rv;
            exp_a = a_in;
            exp_b = b_in;
            exp_v = valid_in;
            if (old_rv != 0 && result_ready) exp_rv = 0;
            if (clear) begin
                terms.delete();
            end else if (valid_in) begin
                terms.push_back((int'(a_in) * int'(b_in)) % 256);
                if (terms.size() == K0) begin
                    int sum;
                    sum = 0;
                    foreach (terms[k]) sum += terms[k];
                    exp_res = sum % (1 << W0);
                    if (old_rv != 0 && !result_ready) exp_ovf = 1;
                    exp_rv = 1;
                    terms.delete();
                end
            end
            exp_busy = (terms.size() > 0) ? 1 : 0;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("cyc_a_out", int'(a_out0), exp_a);
            checkOutput("cyc_b_out", int'(b_out0), exp_b);
            checkOutput("cyc_valid_out", int'(valid_out0), exp_v);
            checkOutput("cyc_result", int'(result0), exp_res);
            checkOutput("cyc_result_valid", int'(rv0), exp_rv);
            checkOutput("cyc_result_ovf", int'(ovf0), exp_ovf);
            checkOutput("cyc_busy", int'(busy0), exp_busy);
        end
    end

    // Holds the inputs across one rising edge, returning just after it.
    task automatic applyStimulus(input int a, input int b, input bit v, input bit clr);
        a_in = 8'(a);
        b_in = 8'(b);
        valid_in = v;
        clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        applyStimulus(0, 0, 0, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        $display("[TB] start");
        doReset();
        applyStimulus(0, 0, 0, 0);
        reset_n = 1'b0;
        applyStimulus(0, 0, 0, 0);
        reset_n = 1'b1;
        chk_en = 1'b1;
        checkOutput("rst_result", int'(result0), 0);
        checkOutput("rst_result_valid", int'(rv0), 0);
        checkOutput("rst_busy", int'(busy0), 0);
        checkOutput("rst_valid_out", int'(valid_out0), 0);

        // Basic dot product with ready high
        result_ready = 1'b1;
        applyStimulus(3, 5, 1, 0);
        checkOutput("basic_a_lag", int'(a_out0), 3);
        checkOutput("basic_b_lag", int'(b_out0), 5);
        applyStimulus(2, 7, 1, 0);
        applyStimulus(10, 10, 1, 0);
        applyStimulus(1, 1, 1, 0);
        checkOutput("basic_result", int'(result0), 130);
        checkOutput("basic_rv_high", int'(rv0), 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("basic_rv_one_cycle", int'(rv0), 0);

        // Truncated products
        applyStimulus(16, 16, 1, 0);
        applyStimulus(255, 255, 1, 0);
        applyStimulus(2, 3, 1, 0);
        applyStimulus(0, 9, 1, 0);
        checkOutput("trunc_result", int'(result0), 7);

        // Gaps and clear
        applyStimulus(4, 4, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 0);
        applyStimulus(5, 5, 1, 0);
        checkOutput("gap_busy", int'(busy0), 1);
        applyStimulus(9, 9, 1, 1);
        checkOutput("clear_busy", int'(busy0), 0);
        applyStimulus(1, 2, 1, 0);
        applyStimulus(1, 3, 1, 0);
        applyStimulus(1, 4, 1, 0);
        applyStimulus(1, 5, 1, 0);
        checkOutput("clear_result", int'(result0), 14);

        // Backpressure and overflow
        result_ready = 1'b0;
        repeat (4) applyStimulus(1, 1, 1, 0);
        checkOutput("bp_first_result", int'(result0), 4);
        repeat (4) applyStimulus(2, 2, 1, 0);
        checkOutput("bp_result", int'(result0), 16);
        checkOutput("bp_ovf", int'(ovf0), 1);
        checkOutput("bp_rv", int'(rv0), 1);
        result_ready = 1'b1;
        applyStimulus(0, 0, 0, 0);
        checkOutput("bp_rv_drop", int'(rv0), 0);
        checkOutput("bp_ovf_sticky", int'(ovf0), 1);

        // Wrap on the narrow instance
        doReset();
        applyStimulus(20, 10, 1, 0);
        applyStimulus(10, 10, 1, 0);
        checkOutput("wrap_result", int'(result1), 44);
        checkOutput("wrap_rv", int'(rv1), 1);

        // Reset in the middle of an accumulation
        checkOutput("midrst_busy_before", int'(busy0), 1);
        reset_n = 1'b0;
        applyStimulus(7, 7, 1, 0);
        checkOutput("midrst_a_out", int'(a_out0), 0);
        checkOutput("midrst_valid_out", int'(valid_out0), 0);
        checkOutput("midrst_result", int'(result0), 0);
        checkOutput("midrst_ovf", int'(ovf0), 0);
        checkOutput("midrst_busy", int'(busy0), 0);
        checkOutput("midrst_rv", int'(rv0), 0);
        reset_n = 1'b1;
        repeat (4) applyStimulus(1, 1, 1, 0);
        checkOutput("midrst_result_after", int'(result0), 4);

        // Randomized traffic, checked by the per-cycle model
        for (int i = 0; i < 600; i++) begin
            result_ready = ($urandom_range(0, 9) < 6);
            reset_n = ($urandom_range(0, 149) != 0);
            applyStimulus($urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end
        reset_n = 1'b1;
        result_ready = 1'b1;
        repeat (3) applyStimulus(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
